// File: rtl/time_pkg.sv
// Shared types and constants for the seconds-to-BCD time converter.
package time_pkg;
  typedef enum logic [1:0] {IDLE, DIV_S, DIV_M, FORMAT} state_e;

  localparam int SECS_PER_MIN = 60;
  localparam int BCD_DIGIT_W  = 4;
  localparam int FIELD_MAX    = 99;
  localparam int REM_W        = 6;

  localparam logic [15:0] SAT_MMSS   = 16'h9959;
  localparam logic [23:0] SAT_HHMMSS = 24'h995959;

  // Two-digit BCD of a value known to be below 100.
  function automatic logic [2*BCD_DIGIT_W-1:0] bin_to_bcd2(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction
endpackage

// File: rtl/divmod60_seq.sv
// Sequential restoring divide-by-60, one quotient bit per clock.
module divmod60_seq
  import time_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [REM_W-1:0] remainder
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [REM_W:0] DIVISOR = SECS_PER_MIN[REM_W:0];

  logic [WIDTH-1:0] quo_q, quo_d, quo_step;
  logic [REM_W-1:0] rem_q, rem_d, rem_sub, rem_step;
  logic [REM_W:0]   rem_shift;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             ge;
  logic             last;

  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    ge        = (rem_shift >= DIVISOR);
    // rem_shift < 120, so the 6-bit wrapped difference is exact whenever ge
    rem_sub   = rem_shift[REM_W-1:0] - DIVISOR[REM_W-1:0];
    rem_step  = ge ? rem_sub : rem_shift[REM_W-1:0];
    quo_step  = {quo_q[WIDTH-2:0], ge};
    last      = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

    quo_d  = quo_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      quo_d  = din;
      rem_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      quo_d = quo_step;
      rem_d = rem_step;
      cnt_d = cnt_q + 1'b1;
      if (last) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // Results are final (combinationally) in the cycle done is high, so a
  // caller can chain a second division on the very same edge.
  assign busy      = busy_q;
  assign done      = last;
  assign quotient  = quo_step;
  assign remainder = rem_step;
endmodule

// File: rtl/seconds_to_bcd_seq.sv
// Converts a binary seconds count to packed BCD MM:SS or HH:MM:SS with
// valid/ready handshakes on both sides and saturation of the top field.
module seconds_to_bcd_seq
  import time_pkg::*;
#(
  parameter  int COUNT_W  = 12,
  parameter  int HOURS_EN = 0,
  localparam int TIME_W   = (HOURS_EN != 0) ? 24 : 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COUNT_W-1:0] count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TIME_W-1:0]  time_out,
  output logic               ovf
);
  state_e              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [TIME_W-1:0]   time_q, time_d;
  logic                ovf_q, ovf_d;
  logic [REM_W-1:0]    secs_q, secs_d, mins_q, mins_d;
  logic [COUNT_W-1:0]  top_q, top_d;
  logic                accept;
  logic                div_start, div_busy, div_done, div_last;
  logic [COUNT_W-1:0]  div_din, div_quo;
  logic [REM_W-1:0]    div_rem;

  // Returns {ovf, time}; the top field (minutes or hours) may exceed 99.
  function automatic logic [TIME_W:0] format_time(input logic [COUNT_W-1:0] top,
                                                  input logic [REM_W-1:0]   mins,
                                                  input logic [REM_W-1:0]   secs);
    logic              sat;
    logic [TIME_W-1:0] t;
    sat = (top > COUNT_W'(FIELD_MAX));
    if (HOURS_EN != 0)
      t = sat ? TIME_W'(SAT_HHMMSS)
              : TIME_W'({bin_to_bcd2(top[6:0]), bin_to_bcd2({1'b0, mins}),
                         bin_to_bcd2({1'b0, secs})});
    else
      t = sat ? TIME_W'(SAT_MMSS)
              : TIME_W'({bin_to_bcd2(top[6:0]), bin_to_bcd2({1'b0, secs})});
    return {sat, t};
  endfunction

  divmod60_seq #(.WIDTH(COUNT_W)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .din       (div_din),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign div_last = div_busy && div_done;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    time_d      = time_q;
    ovf_d       = ovf_q;
    secs_d      = secs_q;
    mins_d      = mins_q;
    top_d       = top_q;
    div_start   = 1'b0;
    div_din     = count;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          div_start   = 1'b1;
          out_valid_d = 1'b0;
          state_d     = DIV_S;
        end
      end
      DIV_S: begin
        if (div_last) begin
          secs_d = div_rem;
          top_d  = div_quo;
          if (HOURS_EN != 0) begin
            div_start = 1'b1;
            div_din   = div_quo;
            state_d   = DIV_M;
          end else begin
            state_d = FORMAT;
          end
        end
      end
      DIV_M: begin
        if (div_last) begin
          mins_d  = div_rem;
          top_d   = div_quo;
          state_d = FORMAT;
        end
      end
      FORMAT: begin
        {ovf_d, time_d} = format_time(top_q, mins_q, secs_q);
        out_valid_d     = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      time_q      <= '0;
      ovf_q       <= 1'b0;
      secs_q      <= '0;
      mins_q      <= '0;
      top_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      time_q      <= time_d;
      ovf_q       <= ovf_d;
      secs_q      <= secs_d;
      mins_q      <= mins_d;
      top_q       <= top_d;
    end
  end

  assign out_valid = out_valid_q;
  assign time_out  = time_q;
  assign ovf       = ovf_q;
endmodule

// File: doc/seconds_to_bcd_seq.md
SECONDS_TO_BCD_SEQ -- requirements
Module: seconds_to_bcd_seq

Interface
REQ-001 The block SHALL have parameter COUNT_W, default 12, giving the binary seconds-count input width (legal range 8..20).
REQ-002 The block SHALL have parameter HOURS_EN, default 0: 0 = MM:SS output, 1 = HH:MM:SS output.
REQ-003 The block SHALL have derived localparam TIME_W = HOURS_EN ? 24 : 16.
REQ-004 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: rst_n  input  1  reset; asynchronous and active-low.
REQ-006 Port: in_valid  input  1  count is valid.
REQ-007 Port: in_ready  output  1  block can accept count this cycle.
REQ-008 Port: count  input  COUNT_W  binary seconds, unsigned.
REQ-009 Port: out_valid  output  1  time_out and ovf are valid.
REQ-010 Port: out_ready  input  1  consumer takes the result this cycle.
REQ-011 Port: time_out  output  TIME_W  packed BCD, 4 bits per digit, MSB first: [HH]MMSS, seconds units in [3:0].
REQ-012 Port: ovf  output  1  result saturated.

Function
REQ-013 The FSM SHALL have states IDLE, DIV_S, DIV_M, FORMAT.
REQ-014 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready); accept happens when in_valid && in_ready at a rising edge.
REQ-015 On accept, the block SHALL register count and go to DIV_S, clearing out_valid unless a new result is produced.
REQ-016 DIV_S SHALL perform restoring division by 60, one quotient bit per cycle, for exactly COUNT_W cycles, giving secs = count mod 60 and q1 = count / 60.
REQ-017 After DIV_S: HOURS_EN=0 -> FORMAT; HOURS_EN=1 -> DIV_M, which divides q1 by 60 over COUNT_W cycles (mins = q1 mod 60, hrs = q1 / 60), then FORMAT.
REQ-018 FORMAT SHALL take one cycle: split each field (<100) into tens/units BCD, load time_out, set out_valid, and return to IDLE.
REQ-019 Latency SHALL be: out_valid rises on rising edge COUNT_W+1 after the accepting edge (HOURS_EN=0), or 2*COUNT_W+1 (HOURS_EN=1).
REQ-020 If the top field exceeds 99 (minutes when HOURS_EN=0, hours when HOURS_EN=1), time_out SHALL saturate to all fields 99 except SS=59 and MM=59 where applicable (MM:SS -> 99:59; HH:MM:SS -> 99:59:59), and ovf SHALL be 1; otherwise ovf SHALL be 0.
REQ-021 time_out and ovf SHALL hold stable while out_valid && !out_ready; out_valid SHALL drop on the edge where out_ready is sampled high, unless a new accept occurs on that same edge, in which case out_valid drops and the new conversion starts.
REQ-022 in_valid during DIV_S/DIV_M/FORMAT SHALL be ignored; count is sampled only at accept.
REQ-023 count = 0 SHALL give time_out = 0 with full latency, with no shortcut.

Reset
REQ-024 While rst_n is low: state = IDLE, out_valid = 0, time_out = 0, ovf = 0, and all datapath registers = 0; in_ready SHALL be 1 one cycle after deassertion.
REQ-025 Reset asserted mid-conversion SHALL abort the conversion with no result emitted; the next accept after release SHALL convert normally.

Structure
REQ-026 Package time_pkg SHALL hold the FSM state enum, the constant SECS_PER_MIN = 60, BCD_DIGIT_W = 4, and the saturation constants.
REQ-027 Division SHALL be a sub-module divmod60_seq (parameter WIDTH; start/busy/done; quotient, remainder), instantiated once and reused for DIV_S and DIV_M.
REQ-028 The tens/units split of a value below 100 MAY be combinational inside FORMAT.

Verification
REQ-029 COUNT_W=12, HOURS_EN=0: count=90 -> time_out=16'h0130, ovf=0, out_valid exactly 13 edges after accept.
REQ-030 COUNT_W=12: count=3599 -> 16'h5959; count=4095 -> 16'h6815; count=0 -> 16'h0000.
REQ-031 COUNT_W=16, HOURS_EN=0: count=65535 -> 16'h9959, ovf=1; count=5999 -> 16'h9959, ovf=0.
REQ-032 COUNT_W=16, HOURS_EN=1: count=65535 -> 24'h181215, ovf=0, latency 33 edges; count=45296 -> 24'h123456.
REQ-033 Back-pressure: hold out_ready=0 for 10 cycles after result 1397 (16'h2317); time_out stays stable and in_ready=0; then assert out_ready with in_valid high -> handoff and new accept occur on the same edge.
REQ-034 Assert rst_n low at cycle 5 of the conversion of count 345: no out_valid; after release, 345 -> 16'h0545.
